// File: rtl/perf_counter_unit.sv
// Ten event counters with a valid/ready snapshot port and clear-on-snapshot.
// Define PERF_COUNTER_SATURATE_EN for saturating counters plus perfOverflow.
module perf_counter_unit #(
   parameter int COUNTER_WIDTH = 32,
   parameter int MEM_LANES     = 2,
   parameter int INT_LANES     = 2,
   parameter int DEC_LANES     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      countEnable,
   input  logic                      evIcMiss,
   input  logic                      evIcHit,
   input  logic [MEM_LANES-1:0]      evLoadMiss,
   input  logic [MEM_LANES-1:0]      evLoadHit,
   input  logic                      evStoreMiss,
   input  logic                      evStoreHit,
   input  logic [MEM_LANES-1:0]      evStLdFwdFail,
   input  logic                      evMemDepPredMiss,
   input  logic [INT_LANES-1:0]      evBrPredMiss,
   input  logic [DEC_LANES-1:0]      evBrPredMissDec,
   input  logic                      clearReq,
   input  logic                      snapReq,
   input  logic                      snapClear,
   output logic                      snapValid,
   input  logic                      snapReady,
   output logic [10*COUNTER_WIDTH-1:0] snapData,
   output logic [10*COUNTER_WIDTH-1:0] perfLive
`ifdef PERF_COUNTER_SATURATE_EN
   ,
   output logic [9:0]                perfOverflow
`endif
);

   localparam int NCNT = 10;
   localparam logic [0:0] STATE_IDLE = 1'b0;
   localparam logic [0:0] STATE_HOLD = 1'b1;

   logic [NCNT-1:0][COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [NCNT-1:0][COUNTER_WIDTH-1:0] snap_q, snap_d;
   logic [NCNT-1:0][COUNTER_WIDTH-1:0] inc;
   logic [0:0] state_q, state_d;
   logic capture;
   logic clr;

   function automatic logic [COUNTER_WIDTH-1:0] popcnt(input logic [31:0] v);
      logic [COUNTER_WIDTH-1:0] n;
      n = '0;
      for (int k = 0; k < 32; k++) begin
         n = n + COUNTER_WIDTH'(v[k]);
      end
      return n;
   endfunction

   always_comb begin
      inc[0] = popcnt(32'(evIcMiss));
      inc[1] = popcnt(32'(evIcHit));
      inc[2] = popcnt(32'(evLoadMiss));
      inc[3] = popcnt(32'(evLoadHit));
      inc[4] = popcnt(32'(evStoreMiss));
      inc[5] = popcnt(32'(evStoreHit));
      inc[6] = popcnt(32'(evStLdFwdFail));
      inc[7] = popcnt(32'(evMemDepPredMiss));
      inc[8] = popcnt(32'(evBrPredMiss));
      inc[9] = popcnt(32'(evBrPredMissDec));
   end

   // Capture samples the registers, so the capture cycle's events are excluded.
   assign capture = (state_q == STATE_IDLE) && snapReq;
   assign clr     = clearReq || (capture && snapClear);

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      if (state_q == STATE_IDLE) begin
         if (snapReq) begin
            snap_d  = cnt_q;
            state_d = STATE_HOLD;
         end
      end else if (snapReady) begin
         state_d = STATE_IDLE;
      end
   end

`ifdef PERF_COUNTER_SATURATE_EN
   logic [NCNT-1:0] ovf_q, ovf_d;
   logic [COUNTER_WIDTH:0] sum;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      sum   = '0;
      if (clr) begin
         cnt_d = '0;
         ovf_d = '0;
      end else if (countEnable) begin
         for (int i = 0; i < NCNT; i++) begin
            sum = {1'b0, cnt_q[i]} + {1'b0, inc[i]};
            if (sum[COUNTER_WIDTH]) begin
               cnt_d[i] = '1;
               ovf_d[i] = 1'b1;
            end else begin
               cnt_d[i] = sum[COUNTER_WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign perfOverflow = ovf_q;
`else
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (countEnable) begin
         for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = cnt_q[i] + inc[i];
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         snap_q  <= '0;
         state_q <= STATE_IDLE;
      end else begin
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         state_q <= state_d;
      end
   end

   assign snapValid = (state_q == STATE_HOLD);
   assign snapData  = snap_q;
   assign perfLive  = cnt_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: vector table plus snapshot,
// reset and wrap/saturate sequences (narrow second instance for wrap).
module tb_perf_counter_unit;

   logic clk = 1'b0;
   logic rst_n;
   logic cen, icm, ich, stm, sth, mdp, clr, sreq, sclr, srdy;
   logic [1:0] ldm, ldh, fwd, br;
   logic [3:0] brd;
   logic svld, svld_w;
   logic [319:0] sdata, live;
   logic [39:0] sdata_w, live_w;
`ifdef PERF_COUNTER_SATURATE_EN
   logic [9:0] ovf, ovf_w;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   perf_counter_unit dut (
      .clk(clk), .rst_n(rst_n), .countEnable(cen),
      .evIcMiss(icm), .evIcHit(ich),
      .evLoadMiss(ldm), .evLoadHit(ldh),
      .evStoreMiss(stm), .evStoreHit(sth),
      .evStLdFwdFail(fwd), .evMemDepPredMiss(mdp),
      .evBrPredMiss(br), .evBrPredMissDec(brd),
      .clearReq(clr), .snapReq(sreq), .snapClear(sclr),
      .snapValid(svld), .snapReady(srdy),
      .snapData(sdata), .perfLive(live)
`ifdef PERF_COUNTER_SATURATE_EN
      , .perfOverflow(ovf)
`endif
   );

   perf_counter_unit #(.COUNTER_WIDTH(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .countEnable(cen),
      .evIcMiss(icm), .evIcHit(ich),
      .evLoadMiss(ldm), .evLoadHit(ldh),
      .evStoreMiss(stm), .evStoreHit(sth),
      .evStLdFwdFail(fwd), .evMemDepPredMiss(mdp),
      .evBrPredMiss(br), .evBrPredMissDec(brd),
      .clearReq(clr), .snapReq(sreq), .snapClear(sclr),
      .snapValid(svld_w), .snapReady(srdy),
      .snapData(sdata_w), .perfLive(live_w)
`ifdef PERF_COUNTER_SATURATE_EN
      , .perfOverflow(ovf_w)
`endif
   );

   typedef struct {
      logic       cen, icm, ich;
      logic [1:0] ldm, ldh;
      logic       stm, sth;
      logic [1:0] fwd;
      logic       mdp;
      logic [1:0] br;
      logic [3:0] brd;
      logic       clr;
      int         idx;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(
      logic c, logic a, logic b, logic [1:0] lm, logic [1:0] lh,
      logic sm, logic sh, logic [1:0] f, logic m, logic [1:0] bp,
      logic [3:0] bd, logic cl, int ix, logic [31:0] e);
      vec_t v;
      v.cen = c; v.icm = a; v.ich = b; v.ldm = lm; v.ldh = lh;
      v.stm = sm; v.sth = sh; v.fwd = f; v.mdp = m; v.br = bp;
      v.brd = bd; v.clr = cl; v.idx = ix; v.exp = e;
      return v;
   endfunction

   function automatic logic [31:0] cnt(logic [319:0] bus, int i);
      return bus[i*32 +: 32];
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cen = 1'b1; icm = 0; ich = 0; ldm = 0; ldh = 0; stm = 0; sth = 0;
      fwd = 0; mdp = 0; br = 0; brd = 0; clr = 0;
      sreq = 0; sclr = 0; srdy = 0;
   endtask

   int exp_all[10] = '{0, 0, 0, 1, 1, 1, 2, 1, 2, 3};

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++)
         tbl[i] = mk(1,0,1,0,0,0,0,0,0,0,0,0, 1, 32'(i + 1));
      for (int i = 0; i < 3; i++)
         tbl[5+i] = mk(0,0,0,2'b11,0,0,0,0,0,0,0,0, 2, 0);
      for (int i = 0; i < 3; i++)
         tbl[8+i] = mk(1,0,0,2'b11,0,0,0,0,0,0,0,0, 2, 32'(2*i + 2));
      tbl[11] = mk(1,1,0,0,0,0,0,0,0,0,0,0, 0, 1);
      tbl[12] = mk(1,1,0,0,0,0,0,0,0,0,0,1, 0, 0);
      tbl[13] = mk(1,0,0,0,0,0,0,0,0,0,0,0, 2, 0);
      tbl[14] = mk(1,0,0,0,2'b10,0,0,0,0,0,0,0, 3, 1);
      tbl[15] = mk(1,0,0,0,0,1,0,0,0,0,0,0, 4, 1);
      tbl[16] = mk(1,0,0,0,0,0,1,0,0,0,0,0, 5, 1);
      tbl[17] = mk(1,0,0,0,0,0,0,2'b11,0,0,0,0, 6, 2);
      tbl[18] = mk(1,0,0,0,0,0,0,0,1,0,0,0, 7, 1);
      tbl[19] = mk(1,0,0,0,0,0,0,0,0,2'b11,0,0, 8, 2);
      tbl[20] = mk(1,0,0,0,0,0,0,0,0,0,4'b1011,0, 9, 3);
      tbl[21] = mk(0,1,1,2'b11,2'b11,1,1,2'b11,1,2'b11,4'b1111,0, 9, 3);

      step();
      check("rst_valid", 32'(svld), 0);
      check("rst_live_lo", live[31:0], 0);
      check("rst_live_any", 32'(|live), 0);
      check("rst_snap_any", 32'(|sdata), 0);
      step();
      rst_n = 1'b1;

      foreach (tbl[r]) begin
         cen = tbl[r].cen; icm = tbl[r].icm; ich = tbl[r].ich;
         ldm = tbl[r].ldm; ldh = tbl[r].ldh; stm = tbl[r].stm;
         sth = tbl[r].sth; fwd = tbl[r].fwd; mdp = tbl[r].mdp;
         br = tbl[r].br; brd = tbl[r].brd; clr = tbl[r].clr;
         step();
         check($sformatf("vec%0d_cnt%0d", r, tbl[r].idx),
               cnt(live, tbl[r].idx), tbl[r].exp);
      end
      idle_inputs();
      step();
      for (int i = 0; i < 10; i++)
         check($sformatf("table_end_cnt%0d", i), cnt(live, i), 32'(exp_all[i]));

      // snapshot with clear, hold, accept, back-to-back recapture
      clr = 1;
      step();
      clr = 0;
      br = 2'b11;
      repeat (5) step();
      check("preload_cnt8", cnt(live, 8), 10);
      sreq = 1; sclr = 1; br = 2'b01;
      step();
      check("capA_valid", 32'(svld), 1);
      check("capA_snap8", cnt(sdata, 8), 10);
      check("capA_snap3", cnt(sdata, 3), 0);
      check("capA_live8", cnt(live, 8), 0);
      sclr = 0; br = 2'b11;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("hold%0d_valid", i), 32'(svld), 1);
         check($sformatf("hold%0d_snap8", i), cnt(sdata, 8), 10);
      end
      check("hold_live8", cnt(live, 8), 8);
      srdy = 1; br = 0;
      step();
      check("accept_valid", 32'(svld), 0);
      check("accept_snap8", cnt(sdata, 8), 10);
      step();
      check("b2b_valid", 32'(svld), 1);
      check("b2b_snap8", cnt(sdata, 8), 8);
      sreq = 0;
      step();
      check("b2b_accept", 32'(svld), 0);

      // clearReq during HOLD leaves snapshot intact
      sreq = 1; srdy = 0; br = 2'b01;
      step();
      check("cap2_snap8", cnt(sdata, 8), 8);
      sreq = 0; clr = 1;
      step();
      check("holdclr_live8", cnt(live, 8), 0);
      check("holdclr_snap8", cnt(sdata, 8), 8);
      check("holdclr_valid", 32'(svld), 1);
      clr = 0; br = 2'b11;
      step();
      check("prerst_live8", cnt(live, 8), 2);

      // async reset mid-HOLD, between clock edges
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(svld), 0);
      check("arst_live", 32'(|live), 0);
      check("arst_snap", 32'(|sdata), 0);
      #1 rst_n = 1'b1;
      idle_inputs();
      step();

      // wrap/saturate on the 4-bit instance, counter 9
      brd = 4'b1111;
      repeat (3) step();
      brd = 4'b0011;
      step();
      brd = 4'b0001;
      step();
      check("w_cnt9_max", 32'(live_w[36 +: 4]), 32'hF);
      brd = 4'b0011;
      step();
      check("main_cnt9", cnt(live, 9), 17);
`ifdef PERF_COUNTER_SATURATE_EN
      check("w_cnt9_sat", 32'(live_w[36 +: 4]), 32'hF);
      check("w_ovf", 32'(ovf_w), 32'h200);
      check("main_ovf", 32'(ovf), 0);
      brd = 0; clr = 1;
      step();
      check("w_ovf_clr", 32'(ovf_w), 0);
`else
      check("w_cnt9_wrap", 32'(live_w[36 +: 4]), 32'h1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Collects per-cycle event pulses from the fetch, memory, integer and decode pipelines into ten 32-bit performance counters.
- Feeds the live counter bus into the debug register's perfCounter fields every cycle.
- Provides a valid/ready snapshot port with optional clear-on-snapshot, so software or the host bench can read a coherent set of counters.

Parameters:
- COUNTER_WIDTH, 32: width of each counter (matches DataPath).
- MEM_LANES, 2: memory issue lanes (MEM_ISSUE_WIDTH).
- INT_LANES, 2: integer issue lanes (INT_ISSUE_WIDTH).
- DEC_LANES, 4: decode lanes (DECODE_WIDTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- countEnable  in  1  global count enable; 0 freezes all live counters.
- evIcMiss  in  1  I-cache miss this cycle.
- evIcHit  in  1  I-cache hit this cycle.
- evLoadMiss  in  MEM_LANES  per-lane load miss.
- evLoadHit  in  MEM_LANES  per-lane load hit.
- evStoreMiss  in  1  store commit miss.
- evStoreHit  in  1  store commit hit.
- evStLdFwdFail  in  MEM_LANES  per-lane store-load forwarding failure.
- evMemDepPredMiss  in  1  memory dependence mispredict.
- evBrPredMiss  in  INT_LANES  per-lane branch mispredict at execute.
- evBrPredMissDec  in  DEC_LANES  per-lane mispredict detected at decode.
- clearReq  in  1  synchronous clear of live counters.
- snapReq  in  1  request a snapshot (level; sampled only in IDLE).
- snapClear  in  1  with snapReq: clear live counters in the capture cycle.
- snapValid  out  1  snapshot bus holds valid data.
- snapReady  in  1  consumer accepts snapshot.
- snapData  out  10*COUNTER_WIDTH  captured counters, index 0 in LSBs.
- perfLive  out  10*COUNTER_WIDTH  live counters, same packing.

Behaviour:
- Counter index order:
  - 0 IcMiss, 1 IcHit, 2 LoadMiss, 3 LoadHit, 4 StoreMiss, 5 StoreHit.
  - 6 StLdFwdFail, 7 MemDepPredMiss, 8 BrPredMiss, 9 BrPredMissDec.
- Increment per cycle = popcount of the corresponding event vector, zero-extended to COUNTER_WIDTH. Increments are applied only when countEnable=1.
- Live counters are registered; perfLive = register contents. Events at edge N are visible on perfLive after edge N+1 (1-cycle latency).
- Overflow without the optional feature: modulo 2^COUNTER_WIDTH wrap.
- Reset (rst_n=0, async): all live counters 0, snapData 0, snapValid 0, FSM to IDLE.
- Snapshot FSM states:
  - IDLE: snapValid=0. If snapReq=1, capture snapData <= live register values as at the start of the cycle, excluding that cycle's events. Go to HOLD.
  - HOLD: snapValid=1 and snapData is stable. Counting continues in the live registers. On snapValid&&snapReady, go to IDLE at the next edge. snapReq is ignored while in HOLD.
- Minimum snapshot cycle is 2 clocks: capture edge, then accept edge. Back-to-back snapReq re-captures on the first IDLE cycle after accept.
- Clear priority, highest first:
  1. clearReq, or snapClear in an IDLE capture cycle: live counters <= 0 and that cycle's events are dropped.
  2. Otherwise, normal increment.
- A clear in the capture cycle still captures the pre-clear values into snapData.
- clearReq in HOLD clears live counters only; snapData is unaffected.
- Asserting rst_n low mid-HOLD drops the snapshot (snapValid -> 0 immediately).

Optional Feature:
- PERF_COUNTER_SATURATE_EN defined:
  - Counters saturate at 2^COUNTER_WIDTH-1 instead of wrapping; an increment that would exceed the max sets the counter to the max.
  - Adds output perfOverflow (10 bits): a sticky per-counter flag, set on any saturating increment.
  - perfOverflow is cleared by reset, by clearReq, and by snapClear in the capture cycle.
  - It is registered alongside the counters, with the same 1-cycle latency.
- Not defined: modulo wrap and no perfOverflow port.

Test Plan:
- Reset then 5 cycles with evIcHit=1 and countEnable=1 -> perfLive[1] = 5 one cycle after the last event; all other counters 0.
- evLoadMiss=2'b11 for 3 cycles with MEM_LANES=2 -> counter 2 = 6. Same stimulus with countEnable=0 -> counter 2 stays 0.
- Counter 8 preloaded to 10 by events:
  - Cycle A: snapReq=1, snapClear=1, evBrPredMiss=2'b01 -> snapData[8]=10 and snapValid=1 next cycle; live counter 8 = 0 (event dropped).
  - Hold snapReady=0 for 4 cycles -> snapData stable and snapValid=1.
  - Assert snapReady -> snapValid=0 next cycle.
- clearReq=1 with evIcMiss=1 in the same cycle -> counter 0 = 0 the next cycle.
- Wrap/saturate check:
  - Without PERF_COUNTER_SATURATE_EN: drive counter 9 to 0xFFFFFFFF, then evBrPredMissDec=4'b0011 -> counter 9 = 0x00000001.
  - With PERF_COUNTER_SATURATE_EN: same stimulus -> counter 9 = 0xFFFFFFFF and perfOverflow[9]=1; clearReq -> perfOverflow = 0.
- rst_n pulsed low for a partial cycle during HOLD -> snapValid and all counters 0 immediately, without waiting for a clock edge.
